// File: rtl/perf_pkg.sv
// Shared definitions for the performance counter bank.
// State encoding, default sizing and readout-select sizing helpers.
package perf_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CNT  = 1'b1
    } state_t;

    localparam int CNT_W_DEF   = 32;
    localparam int NUM_EVT_DEF = 4;
    localparam int SEL_W_DEF   = 4;
    localparam int CYC_IDX     = NUM_EVT_DEF;

    // The cycle counter always sits just above the last event channel.
    function automatic int cyc_idx(input int num_evt);
        return num_evt;
    endfunction

    function automatic bit sel_fits(input int sel_w, input int num_evt);
        return (2 ** sel_w) >= (num_evt + 1);
    endfunction

endpackage

// File: rtl/perf_cnt_chan.sv
// One counter channel: clear, enable-gated increment, sticky overflow.
// PERF_CNT_SAT_EN selects saturate-at-max instead of wrap-to-zero.
module perf_cnt_chan #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (en && inc) begin
            if (cnt == MAX) begin
                ovf <= 1'b1;
`ifdef PERF_CNT_SAT_EN
                cnt <= MAX;
`else
                cnt <= '0;
`endif
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Cycle counter plus NUM_EVT event counters sharing one start/stop window.
// Overflow mode follows PERF_CNT_SAT_EN (saturate) or wraps by default.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int NUM_EVT = NUM_EVT_DEF,
    parameter int SEL_W   = SEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               strcnt,
    input  logic               stpcnt,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               rd_en,
    input  logic [SEL_W-1:0]   rd_sel,
    output logic [CNT_W-1:0]   rd_data,
    output logic               rd_valid,
    output logic [NUM_EVT:0]   ovf,
    output logic               running
);

    localparam int NCH = NUM_EVT + 1;
    localparam int CYC = cyc_idx(NUM_EVT);

    if (!sel_fits(SEL_W, NUM_EVT)) begin : g_sel_chk
        $error("SEL_W too narrow for NUM_EVT+1 channels");
    end

    state_t           state;
    state_t           state_nxt;
    logic             clr;
    logic [NCH-1:0]   inc;
    logic [CNT_W-1:0] cnt [NCH];
    logic [CNT_W-1:0] rd_mux;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Start is only honoured in IDLE, stop only in CNT.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        unique case (state)
            IDLE: begin
                if (strcnt) begin
                    state_nxt = CNT;
                    clr       = 1'b1;
                end
            end
            CNT: begin
                if (stpcnt) state_nxt = IDLE;
            end
        endcase
    end

    assign running = (state == CNT);
    assign inc     = {1'b1, evt};

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        perf_cnt_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .en  (running),
            .inc (inc[i]),
            .cnt (cnt[i]),
            .ovf (ovf[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_sel == SEL_W'(i)) rd_mux = cnt[i];
        end
        if (rd_sel == SEL_W'(CYC)) rd_mux = cnt[CYC];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank with a running-total reference model.
// Build with PERF_CNT_SAT_EN to exercise the saturating variant.
module tb_perf_counter_bank;

    localparam int CNT_W   = 4;
    localparam int NUM_EVT = 4;
    localparam int SEL_W   = 4;
    localparam int NCH     = NUM_EVT + 1;
    localparam int MAXV    = 15;
`ifdef PERF_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               strcnt = 1'b0;
    logic               stpcnt = 1'b0;
    logic [NUM_EVT-1:0] evt = '0;
    logic               rd_en = 1'b0;
    logic [SEL_W-1:0]   rd_sel = '0;
    logic [CNT_W-1:0]   rd_data;
    logic               rd_valid;
    logic [NUM_EVT:0]   ovf;
    logic               running;

    perf_counter_bank #(
        .CNT_W   (CNT_W),
        .NUM_EVT (NUM_EVT),
        .SEL_W   (SEL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .strcnt   (strcnt),
        .stpcnt   (stpcnt),
        .evt      (evt),
        .rd_en    (rd_en),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .ovf      (ovf),
        .running  (running)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: unbounded event totals per window; counter view derived from them.
    int tot [NCH];
    bit m_run   = 1'b0;
    bit m_valid = 1'b0;
    int m_data  = 0;
    bit chk_en  = 1'b0;

    function automatic int exp_cnt(input int t);
        if (SAT) return (t > MAXV) ? MAXV : t;
        return t % (MAXV + 1);
    endfunction

    function automatic logic [NCH-1:0] exp_ovf();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = (tot[i] > MAXV);
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) tot[i] = 0;
            m_run   = 1'b0;
            m_valid = 1'b0;
            m_data  = 0;
            chk_en  = 1'b1;
        end else begin
            m_valid = rd_en;
            if (rd_en) begin
                if (int'(rd_sel) <= NUM_EVT) m_data = exp_cnt(tot[rd_sel]);
                else                         m_data = 0;
            end
            if (!m_run) begin
                if (strcnt) begin
                    m_run = 1'b1;
                    for (int i = 0; i < NCH; i++) tot[i] = 0;
                end
            end else begin
                for (int i = 0; i < NUM_EVT; i++) if (evt[i]) tot[i]++;
                tot[NUM_EVT]++;
                if (stpcnt) m_run = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("running", 32'(running), 32'(m_run));
            check("ovf", 32'(ovf), 32'(exp_ovf()));
            check("rd_valid", 32'(rd_valid), 32'(m_valid));
            check("rd_data", 32'(rd_data), m_data);
        end
    end

    task automatic step(input logic s, input logic p, input logic [3:0] e,
                        input logic re, input logic [3:0] rs);
        strcnt = s;
        stpcnt = p;
        evt    = e;
        rd_en  = re;
        rd_sel = rs;
        @(negedge clk);
    endtask

    task automatic rd(input logic [3:0] sel);
        step(1'b0, 1'b0, 4'h0, 1'b1, sel);
    endtask

    initial begin
        // Reset with random inputs
        rst = 1'b0;
        for (int c = 0; c < 2; c++)
            step(1'($urandom), 1'($urandom), 4'($urandom),
                 1'($urandom), 4'($urandom));
        check("rst_running", 32'(running), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_data", 32'(rd_data), 0);
        rst = 1'b1;
        step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);

        // Basic window of 10 cycles, 5 events on ch0
        step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        for (int c = 1; c <= 10; c++)
            step(1'b0, c == 10, (c <= 5) ? 4'h1 : 4'h0, 1'b0, 4'h0);
        rd(4'd4);
        check("win_cyc", 32'(rd_data), 10);
        rd(4'd0);
        check("win_ch0", 32'(rd_data), 5);
        check("win_ovf", 32'(ovf), 0);

        // Overflow on ch1 and cycle counter after 17 increments
        step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        for (int c = 1; c <= 17; c++)
            step(1'b0, c == 17, 4'h2, 1'b0, 4'h0);
        rd(4'd1);
        check("ovf_ch1", 32'(rd_data), SAT ? 15 : 1);
        check("ovf_bit1", 32'(ovf[1]), 1);
        rd(4'd4);
        check("ovf_cyc", 32'(rd_data), SAT ? 15 : 1);
        check("ovf_bit4", 32'(ovf[4]), 1);

        // Start and stop together: IDLE starts, CNT stops
        step(1'b1, 1'b1, 4'h0, 1'b0, 4'h0);
        check("both_idle_run", 32'(running), 1);
        check("both_idle_ovf", 32'(ovf), 0);
        rd(4'd4);
        check("both_idle_cyc", 32'(rd_data), 0);
        for (int c = 0; c < 17; c++)
            step(1'b0, 1'b0, 4'h2, 1'b0, 4'h0);
        step(1'b1, 1'b1, 4'h0, 1'b0, 4'h0);
        check("both_cnt_run", 32'(running), 0);
        check("both_cnt_ovf", 32'(ovf[1]), 1);
        rd(4'd1);
        check("both_cnt_ch1", 32'(rd_data), SAT ? 15 : 1);
        step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        check("restart_ovf", 32'(ovf), 0);
        step(1'b0, 1'b1, 4'h0, 1'b0, 4'h0);

        // Invalid select, then pre-increment snapshot in CNT
        rd(4'd5);
        check("inv_valid", 32'(rd_valid), 1);
        check("inv_data", 32'(rd_data), 0);
        step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        for (int c = 0; c < 3; c++)
            step(1'b0, 1'b0, 4'h1, 1'b0, 4'h0);
        step(1'b0, 1'b0, 4'h1, 1'b1, 4'd0);
        check("pre_inc_ch0", 32'(rd_data), 3);
        step(1'b0, 1'b1, 4'h0, 1'b0, 4'h0);

        // Reset in the middle of a window
        step(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
        for (int c = 1; c <= 6; c++)
            step(1'b0, 1'b0, 4'hf, 1'b0, 4'h0);
        rst = 1'b0;
        step(1'b0, 1'b0, 4'hf, 1'b0, 4'h0);
        rst = 1'b1;
        check("mid_rst_run", 32'(running), 0);
        check("mid_rst_ovf", 32'(ovf), 0);
        step(1'b0, 1'b1, 4'h0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'h0, 1'b0, 4'h0);
        rd(4'd4);
        check("mid_rst_cyc", 32'(rd_data), 0);
        rd(4'd0);
        check("mid_rst_ch0", 32'(rd_data), 0);
        check("mid_rst_idle", 32'(running), 0);

        step(1'b0, 1'b0, 4'h0, 1'b0, 4'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
